// File: rtl/pwm_bank_pkg.sv
// pwm_bank_pkg: shared encodings for the multi-channel PWM bank.
package pwm_bank_pkg;

  // Counting mode, as held in the mode shadow register
  localparam logic MODE_EDGE   = 1'b0;
  localparam logic MODE_CENTER = 1'b1;

  // Center-aligned counting direction
  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage : pwm_bank_pkg

// File: rtl/pwm_timebase.sv
// pwm_timebase: shared prescaler, up/up-down counter, period boundary detect
// and registered period_start pulse. Exposes the next-state counter so the
// channel compares can be registered in lockstep with the counter.
module pwm_timebase
  import pwm_bank_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  run,
  input  logic                  shadow_mode,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [WIDTH-1:0]      cnt_next,
  output logic                  boundary,
  output logic                  period_start
);

  localparam logic [WIDTH-1:0]      CNT_MAX  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0]      CNT_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0]      CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [PRESCALE_W-1:0] PRE_ZERO = {PRESCALE_W{1'b0}};
  localparam logic [PRESCALE_W-1:0] PRE_ONE  = {{(PRESCALE_W-1){1'b0}}, 1'b1};

  logic [PRESCALE_W-1:0] pre_cnt_r;
  logic [PRESCALE_W-1:0] pre_cnt_next_s;
  logic [WIDTH-1:0]      cnt_r;
  logic [WIDTH-1:0]      cnt_next_s;
  logic                  dir_r;
  logic                  dir_next_s;
  logic                  tick_s;
  logic                  boundary_s;
  logic                  period_start_r;

  // Prescaler: count 0..prescale while running, clear when stopped
  always_comb begin
    tick_s         = run && (pre_cnt_r == prescale);
    pre_cnt_next_s = pre_cnt_r;
    if (!run) begin
      pre_cnt_next_s = PRE_ZERO;
    end else if (tick_s) begin
      pre_cnt_next_s = PRE_ZERO;
    end else begin
      pre_cnt_next_s = pre_cnt_r + PRE_ONE;
    end
  end

  // Counter/direction next state and boundary detect per active mode
  always_comb begin
    cnt_next_s = cnt_r;
    dir_next_s = dir_r;
    boundary_s = 1'b0;
    if (!run) begin
      cnt_next_s = CNT_ZERO;
      dir_next_s = DIR_UP;
    end else if (tick_s) begin
      case (shadow_mode)
        MODE_EDGE: begin
          // Wraps MAX->0 naturally; dir parked at up so a switch into
          // center mode always begins counting upwards.
          cnt_next_s = cnt_r + CNT_ONE;
          dir_next_s = DIR_UP;
          boundary_s = (cnt_r == CNT_MAX);
        end
        MODE_CENTER: begin
          if (dir_r == DIR_UP) begin
            if (cnt_r == CNT_MAX) begin
              cnt_next_s = CNT_MAX - CNT_ONE;
              dir_next_s = DIR_DOWN;
            end else begin
              cnt_next_s = cnt_r + CNT_ONE;
              dir_next_s = DIR_UP;
            end
          end else begin
            if (cnt_r == CNT_ONE) begin
              cnt_next_s = CNT_ZERO;
              dir_next_s = DIR_UP;
              boundary_s = 1'b1;
            end else begin
              cnt_next_s = cnt_r - CNT_ONE;
              dir_next_s = DIR_DOWN;
            end
          end
        end
        default: begin
          cnt_next_s = CNT_ZERO;
          dir_next_s = DIR_UP;
        end
      endcase
    end else begin
      cnt_next_s = cnt_r;
      dir_next_s = dir_r;
    end
  end

  // Timebase state registers; period_start marks the cycle cnt re-enters 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt_r      <= PRE_ZERO;
      cnt_r          <= CNT_ZERO;
      dir_r          <= DIR_UP;
      period_start_r <= 1'b0;
    end else begin
      pre_cnt_r      <= pre_cnt_next_s;
      cnt_r          <= cnt_next_s;
      dir_r          <= dir_next_s;
      period_start_r <= boundary_s;
    end
  end

  assign cnt_next     = cnt_next_s;
  assign boundary     = boundary_s;
  assign period_start = period_start_r;

endmodule : pwm_timebase

// File: rtl/pwm_bank.sv
// pwm_bank: CHANNELS PWM outputs on one shared timebase. Duty and mode are
// double-buffered and swap in only at a period boundary (or continuously
// while stopped). Outputs are registered from next-state counter/shadows.
module pwm_bank
  import pwm_bank_pkg::*;
#(
  parameter int CHANNELS   = 8,
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 12
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      run,
  input  logic                      mode,
  input  logic [PRESCALE_W-1:0]     prescale,
  input  logic [CHANNELS-1:0]       out_en,
  input  logic [CHANNELS-1:0]       pwm_en,
  input  logic [CHANNELS*WIDTH-1:0] duty,
  output logic [CHANNELS-1:0]       pwm_out,
  output logic                      period_start
);

  localparam logic [WIDTH-1:0] DUTY_MAX = {WIDTH{1'b1}};

  logic [WIDTH-1:0]          cnt_next_s;
  logic                      boundary_s;
  logic                      shadow_load_s;
  logic [CHANNELS*WIDTH-1:0] shadow_duty_r;
  logic [CHANNELS*WIDTH-1:0] shadow_duty_next_s;
  logic                      shadow_mode_r;
  logic                      shadow_mode_next_s;
  logic [CHANNELS-1:0]       level_s;
  logic [CHANNELS-1:0]       pwm_out_r;

  pwm_timebase #(
    .WIDTH      (WIDTH),
    .PRESCALE_W (PRESCALE_W)
  ) u_timebase (
    .clk          (clk),
    .rst_n        (rst_n),
    .run          (run),
    .shadow_mode  (shadow_mode_r),
    .prescale     (prescale),
    .cnt_next     (cnt_next_s),
    .boundary     (boundary_s),
    .period_start (period_start)
  );

  assign shadow_load_s = !run || boundary_s;

  // Shadow next state: transparent while stopped, capture at boundary
  always_comb begin
    shadow_duty_next_s = shadow_duty_r;
    shadow_mode_next_s = shadow_mode_r;
    if (shadow_load_s) begin
      shadow_duty_next_s = duty;
      shadow_mode_next_s = mode;
    end else begin
      shadow_duty_next_s = shadow_duty_r;
      shadow_mode_next_s = shadow_mode_r;
    end
  end

  // Shadow duty/mode registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_duty_r <= {(CHANNELS*WIDTH){1'b0}};
      shadow_mode_r <= MODE_EDGE;
    end else begin
      shadow_duty_r <= shadow_duty_next_s;
      shadow_mode_r <= shadow_mode_next_s;
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    logic [WIDTH-1:0] ch_duty_s;
    logic             ch_level_s;

    assign ch_duty_s = shadow_duty_next_s[g*WIDTH +: WIDTH];

    // Channel compare: enables first, then full-scale duty forces high
    always_comb begin
      ch_level_s = 1'b0;
      if (!out_en[g]) begin
        ch_level_s = 1'b0;
      end else if (!pwm_en[g]) begin
        ch_level_s = 1'b1;
      end else if (ch_duty_s == DUTY_MAX) begin
        ch_level_s = 1'b1;
      end else begin
        ch_level_s = (cnt_next_s < ch_duty_s);
      end
    end

    assign level_s[g] = ch_level_s;
  end

  // Output register, aligned with the counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_out_r <= {CHANNELS{1'b0}};
    end else begin
      pwm_out_r <= level_s;
    end
  end

  assign pwm_out = pwm_out_r;

endmodule : pwm_bank

// File: tb/tb_pwm_bank.sv
// tb_pwm_bank: directed self-checking bench for pwm_bank (8 ch, 8-bit).
module tb_pwm_bank;

  localparam int CH = 8;
  localparam int W  = 8;
  localparam int PW = 12;

  logic            clk;
  logic            rst_n;
  logic            run;
  logic            mode;
  logic [PW-1:0]   prescale;
  logic [CH-1:0]   out_en;
  logic [CH-1:0]   pwm_en;
  logic [CH*W-1:0] duty;
  logic [CH-1:0]   pwm_out;
  logic            period_start;

  int checks;
  int errors;
  int hi [CH];
  int lat;
  int h1;

  pwm_bank #(
    .CHANNELS   (CH),
    .WIDTH      (W),
    .PRESCALE_W (PW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .run          (run),
    .mode         (mode),
    .prescale     (prescale),
    .out_en       (out_en),
    .pwm_en       (pwm_en),
    .duty         (duty),
    .pwm_out      (pwm_out),
    .period_start (period_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Count high samples per channel over n cycles, starting at the current sample
  task automatic measure(input int n);
    for (int c = 0; c < CH; c++) hi[c] = 0;
    for (int i = 0; i < n; i++) begin
      for (int c = 0; c < CH; c++) hi[c] += int'(pwm_out[c]);
      step(1);
    end
  endtask

  // Cycles until the next period_start sample (at least one step), bounded
  task automatic wait_ps(input int max, output int cnt);
    cnt = 0;
    do begin
      step(1);
      cnt++;
    end while (!period_start && cnt < max);
  endtask

  task automatic set_duty(input int ch, input logic [W-1:0] v);
    duty[ch*W +: W] = v;
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst_n    = 1'b0;
    run      = 1'b0;
    mode     = 1'b0;
    prescale = 12'd0;
    out_en   = 8'hDF;   // ch5 disabled
    pwm_en   = 8'hEF;   // ch4 static high
    duty     = 64'd0;
    set_duty(0, 8'h80);
    set_duty(1, 8'h00);
    set_duty(2, 8'hFF);
    set_duty(3, 8'h01);
    set_duty(5, 8'hFF);

    // Reset state
    step(3);
    check("reset_pwm_out", 32'(pwm_out), 32'h00);
    check("reset_period_start", 32'(period_start), 32'd0);

    // Stopped: outputs reflect cnt==0 with transparent shadows
    rst_n = 1'b1;
    step(3);
    check("run0_hold", 32'(pwm_out), 32'h1D);
    check("run0_no_ps", 32'(period_start), 32'd0);

    // Edge mode, prescale 0
    run = 1'b1;
    wait_ps(2000, lat);
    check("edge_first_ps_latency", 32'(lat), 32'd256);
    measure(256);
    check("edge_d80_high", 32'(hi[0]), 32'd128);
    check("edge_d00_high", 32'(hi[1]), 32'd0);
    check("edge_dff_high", 32'(hi[2]), 32'd256);
    check("edge_d01_high", 32'(hi[3]), 32'd1);
    check("pwm_en0_high", 32'(hi[4]), 32'd256);
    check("out_en0_high", 32'(hi[5]), 32'd0);
    check("edge_period_256", 32'(period_start), 32'd1);

    // Edge mode, prescale 3, duty 0x40
    run      = 1'b0;
    prescale = 12'd3;
    set_duty(0, 8'h40);
    step(2);
    run = 1'b1;
    wait_ps(3000, lat);
    check("pre3_first_ps_latency", 32'(lat), 32'd1024);
    measure(1024);
    check("pre3_d40_high", 32'(hi[0]), 32'd256);
    check("pre3_d01_high", 32'(hi[3]), 32'd4);
    check("pre3_period_1024", 32'(period_start), 32'd1);

    // Center mode, prescale 0, duty 0x80
    run      = 1'b0;
    mode     = 1'b1;
    prescale = 12'd0;
    set_duty(0, 8'h80);
    step(2);
    run = 1'b1;
    wait_ps(2000, lat);
    check("center_first_ps_latency", 32'(lat), 32'd510);
    measure(510);
    check("center_d80_high", 32'(hi[0]), 32'd255);
    check("center_d01_high", 32'(hi[3]), 32'd1);
    check("center_dff_high", 32'(hi[2]), 32'd510);
    check("center_period_510", 32'(period_start), 32'd1);

    // Duty write mid-period is deferred to the boundary
    run  = 1'b0;
    mode = 1'b0;
    set_duty(0, 8'h20);
    step(2);
    run = 1'b1;
    wait_ps(2000, lat);
    check("dbuf_first_ps_latency", 32'(lat), 32'd256);
    measure(16);
    h1 = hi[0];
    set_duty(0, 8'hC0);
    measure(240);
    check("dbuf_old_period_high", 32'(h1 + hi[0]), 32'd32);
    check("dbuf_boundary_ps", 32'(period_start), 32'd1);
    measure(256);
    check("dbuf_new_period_high", 32'(hi[0]), 32'd192);
    check("dbuf_next_ps", 32'(period_start), 32'd1);

    // Mode write mid-period is deferred to the boundary
    measure(100);
    mode = 1'b1;
    measure(156);
    check("mode_defer_edge_period", 32'(period_start), 32'd1);
    wait_ps(2000, lat);
    check("mode_defer_center_period", 32'(lat), 32'd510);

    // out_en drop/restore visible one cycle later
    out_en = 8'hDB;
    step(1);
    check("out_en_off", 32'(pwm_out[2]), 32'd0);
    out_en = 8'hDF;
    step(1);
    check("out_en_on", 32'(pwm_out[2]), 32'd1);

    // Reset mid-period
    mode = 1'b0;
    step(50);
    rst_n = 1'b0;
    #1;
    check("midreset_pwm_out", 32'(pwm_out), 32'h00);
    check("midreset_period_start", 32'(period_start), 32'd0);
    step(2);
    rst_n = 1'b1;
    measure(256);
    check("postreset_shadow0_high", 32'(hi[0]), 32'd0);
    check("postreset_first_ps", 32'(period_start), 32'd1);
    measure(256);
    check("postreset_dC0_high", 32'(hi[0]), 32'd192);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_pwm_bank
